// File: rtl/usb4_scr_pkg.sv
// Shared definitions for the USB4 lane scrambler/descrambler pair:
// LFSR geometry, seeds, block framing constants and the framing state type.
package usb4_scr_pkg;

   localparam int LFSR_W = 23;

   // Taps of x^23+x^21+x^16+x^8+x^5+x^2+1 in the left-shifting Fibonacci form
   localparam logic [LFSR_W-1:0] LFSR_TAPS  = 23'h508092;
   localparam logic [LFSR_W-1:0] SEED_LANE0 = 23'h1DBFBC;

   localparam int SCR_BLOCK_BITS = 64;
   localparam int SCR_HDR_BITS   = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD
   } scr_state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/usb4_descrambler_if.sv
// Serial lane bus between the deserializer side (master) and the descrambler (slave).
interface usb4_descrambler_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 data_in;
   logic                 enable;
   logic                 scr_rst;
   logic                 data_out;
   logic                 valid_out;
   logic                 block_start;
   logic                 sync_err;
   logic                 descr_active;
   logic [ERR_CNT_W-1:0] sync_err_cnt;

   modport master (
      output data_in, enable, scr_rst,
      input  data_out, valid_out, block_start, sync_err, descr_active, sync_err_cnt
   );

   modport slave (
      input  data_in, enable, scr_rst,
      output data_out, valid_out, block_start, sync_err, descr_active, sync_err_cnt
   );
endinterface

// File: rtl/usb4_lfsr23.sv
// 23-bit Fibonacci LFSR keystream source shared by the lane scrambler and descrambler.
module usb4_lfsr23
   import usb4_scr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = SEED_LANE0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_adv,
   output logic o_key
);

   logic [LFSR_W-1:0] r_lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= SEED;
      end else if (i_load) begin
         r_lfsr <= SEED;
      end else if (i_adv) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign o_key = r_lfsr[LFSR_W-1];

endmodule

// File: rtl/usb4_descrambler.sv
// Bit-serial USB4 lane descrambler: tracks 66-bit block framing, strips the
// keystream from payload bits, passes sync headers through and counts bad headers.
module usb4_descrambler
   import usb4_scr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED       = SEED_LANE0,
   parameter int                BLOCK_BITS = SCR_BLOCK_BITS,
   parameter int                HDR_BITS   = SCR_HDR_BITS,
   parameter int                ERR_CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   usb4_descrambler_if.slave  bus
);

   localparam int BCW = $clog2(BLOCK_BITS);

   scr_state_t           r_state;
   logic [BCW-1:0]       r_bit_cnt;
   logic                 r_hdr0;
   logic                 r_data_out;
   logic                 r_valid;
   logic                 r_block_start;
   logic                 r_sync_err;
   logic                 r_active;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic w_key;
   logic w_adv;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Keystream only advances on accepted payload bits; scr_rst wins over enable.
   assign w_adv = bus.enable && !bus.scr_rst && (r_state == ST_PAYLOAD);

   usb4_lfsr23 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .i_load (bus.scr_rst),
      .i_adv  (w_adv),
      .o_key  (w_key)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_hdr0        <= 1'b0;
         r_data_out    <= 1'b0;
         r_valid       <= 1'b0;
         r_block_start <= 1'b0;
         r_sync_err    <= 1'b0;
         r_active      <= 1'b0;
         r_err_cnt     <= '0;
      end else begin
         r_valid       <= 1'b0;
         r_block_start <= 1'b0;
         r_sync_err    <= 1'b0;
         if (bus.scr_rst) begin
            r_state   <= ST_HDR;
            r_bit_cnt <= '0;
            r_active  <= 1'b1;
            r_err_cnt <= '0;
         end else if (bus.enable) begin
            r_valid <= 1'b1;
            case (r_state)
               ST_IDLE: begin
                  r_data_out <= bus.data_in;
               end
               ST_HDR: begin
                  r_data_out <= bus.data_in;
                  if (r_bit_cnt == BCW'(HDR_BITS - 1)) begin
                     // 00 and 11 are not legal sync headers
                     if (r_hdr0 == bus.data_in) begin
                        r_sync_err <= 1'b1;
                        r_err_cnt  <= sat_inc(r_err_cnt);
                     end
                     r_state   <= ST_PAYLOAD;
                     r_bit_cnt <= '0;
                  end else begin
                     r_block_start <= (r_bit_cnt == '0);
                     r_hdr0        <= bus.data_in;
                     r_bit_cnt     <= r_bit_cnt + 1'b1;
                  end
               end
               ST_PAYLOAD: begin
                  r_data_out <= bus.data_in ^ w_key;
                  if (r_bit_cnt == BCW'(BLOCK_BITS - 1)) begin
                     r_state   <= ST_HDR;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_bit_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign bus.data_out     = r_data_out;
   assign bus.valid_out    = r_valid;
   assign bus.block_start  = r_block_start;
   assign bus.sync_err     = r_sync_err;
   assign bus.descr_active = r_active;
   assign bus.sync_err_cnt = r_err_cnt;

endmodule

// File: doc/usb4_descrambler.md
Name: usb4_descrambler

Overview:
- Receive-side counterpart of the lane scrambler: bit-serial descrambler for one USB4 lane.
- Strips scrambling from 64-bit payloads framed by 2-bit sync headers (66-bit blocks). Sync bits pass through unscrambled.
- Tracks block framing and flags invalid sync headers.
- Sits between the lane deserializer and the block/ordered-set decoder.

Parameters:
- SEED, 23'h1DBFBC, LFSR value loaded on rst and on scr_rst; must equal the transmitter seed for this lane.
- BLOCK_BITS, 64, payload bits per block.
- HDR_BITS, 2, sync-header bits per block (fixed 2; other values unsupported).
- ERR_CNT_W, 8, width of the saturating sync-error counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- data_in, input, 1, received serial bit.
- enable, input, 1, data_in valid this cycle.
- scr_rst, input, 1, single-cycle pulse: reseed LFSR and realign to block start.
- data_out, output, 1, descrambled bit.
- valid_out, output, 1, data_out valid.
- block_start, output, 1, high with the first sync-header bit of each block.
- sync_err, output, 1, one-cycle pulse: completed header was 00 or 11.
- descr_active, output, 1, high once the first scr_rst has been seen.
- sync_err_cnt, output, ERR_CNT_W, saturating count of sync errors since last scr_rst.

Behaviour:
- LFSR:
  - 23 bits, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, Fibonacci form.
  - fb = l[22]^l[20]^l[15]^l[7]^l[4]^l[1]; next = {l[21:0], fb}; key bit = l[22].
  - This convention is identical to the team scrambler, so a loopback is bit-exact.
- Reset (rst):
  - lfsr=SEED, state=IDLE, bit_cnt=0, hdr=0.
  - All outputs 0, including sync_err_cnt.
  - Asynchronous assert at any time, mid-block included; no partial output after release.
- Latency: exactly 1 cycle. An input with enable at edge N produces valid_out=1 with the matching data_out after edge N+1. valid_out is the registered enable.
- States: IDLE, HDR, PAYLOAD.
- IDLE:
  - enable bits pass through: data_out=data_in, valid_out=1.
  - LFSR holds; block_start and sync_err stay 0.
- scr_rst (any state):
  - lfsr=SEED, state=HDR, bit_cnt=0, descr_active=1, sync_err_cnt=0.
  - Takes priority over enable in the same cycle; that cycle's data_in is discarded (valid_out=0 next cycle).
- HDR:
  - Each enable bit is output unscrambled and shifted into hdr; LFSR does not advance.
  - bit_cnt 0: block_start=1 with that output.
  - bit_cnt 1: hdr complete. If {hdr0,hdr1} is 00 or 11, pulse sync_err with that output and increment sync_err_cnt (saturate at all-ones). Go to PAYLOAD, bit_cnt=0.
- PAYLOAD:
  - Each enable bit: data_out = data_in ^ l[22]; LFSR advances one step.
  - After bit_cnt=BLOCK_BITS-1, go to HDR, bit_cnt=0.
- enable low (any state): no state, counter or LFSR change; valid_out, block_start and sync_err are 0 next cycle; data_out holds its last value.
- The LFSR never advances on header bits or on idle cycles.
- A sync error does not stop descrambling. Realignment happens only via scr_rst.

Decomposition:
- Shared package usb4_scr_pkg holds:
  - LFSR width (23), polynomial tap list, per-lane seed constants.
  - HDR_BITS/BLOCK_BITS constants.
  - The state enum {IDLE, HDR, PAYLOAD}.
- One natural sub-module: usb4_lfsr23 (seed load, advance enable, key bit out), shared with the scrambler.
- Framing FSM and counters stay in the top module.

Test Plan:
- Idle passthrough: rst release, no scr_rst, enable=1, data_in=1,0,1 -> data_out=1,0,1 one cycle later; descr_active=0, block_start=0.
- Reseed and key: scr_rst, then header 0,1 and 64 zeros -> block_start on first header bit; headers output 0,1; payload outputs equal the first 64 key bits from SEED (first = SEED[22] = 0); sync_err never asserts.
- Loopback: team scrambler (same SEED) feeds this block for 10 blocks of random payload with header 10 -> every descrambled payload bit equals the original; sync_err_cnt=0.
- Header error and saturation: 300 blocks with header 11 -> sync_err pulses once per block on the second header bit; sync_err_cnt stops at 255. A following scr_rst clears it to 0.
- Gaps and priority: enable toggled 1/0 mid-payload -> output identical to gap-free run. scr_rst with enable=1 at payload bit 30 -> no valid_out next cycle; next enable bit is treated as header bit 0 with block_start=1.
- Async reset mid-block: assert rst at payload bit 40, off-edge -> all outputs 0 immediately, state IDLE; after release, data_in passes through unscrambled until scr_rst.
